// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART byte receiver and the 6502 bus.
// Exposes DATA/STATUS/CONTROL registers and a registered level IRQ while bytes are queued.
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uart_byte,
    input  logic       uart_byte_ready,
    input  logic       cs,
    input  logic [1:0] reg_sel,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;

    logic       empty, full;
    logic       pop, push, flush, ovf_set, ovf_clr, ctrl_wr;
    logic [3:0] count4;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_CNT);
    assign count4 = 4'(count_q);

    assign ctrl_wr = cs & we & (reg_sel == 2'd2);
    assign flush   = ctrl_wr & wdata[1];
    assign pop     = cs & ~we & (reg_sel == 2'd0) & ~empty & ~flush;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the byte.
    assign push    = uart_byte_ready & (~full | pop) & ~flush;
    assign ovf_set = uart_byte_ready & full & ~pop & ~flush;
    assign ovf_clr = cs & we & (reg_sel == 2'd1) & wdata[7];

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        irq_en_d   = irq_en_q;

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end

        if (ovf_clr)
            overflow_d = 1'b0;
        if (ovf_set)
            overflow_d = 1'b1;
        if (ctrl_wr)
            irq_en_d = wdata[0];

        irq_d = irq_en_d & (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset)
            mem_q[wr_ptr_q] <= uart_byte;
    end

    always_comb begin
        rdata = 8'h00;
        if (cs) begin
            case (reg_sel)
                2'd0:    rdata = empty ? 8'h00 : mem_q[rd_ptr_q];
                2'd1:    rdata = {overflow_q, irq_q, full, empty, count4};
                2'd2:    rdata = {7'b0, irq_en_q};
                default: rdata = 8'h00;
            endcase
        end
    end

    assign irq = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: register map, ordering, wrap, overflow,
// simultaneous push/pop, control writes and reset mid-burst.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] uart_byte;
    logic       uart_byte_ready;
    logic       cs;
    logic [1:0] reg_sel;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq;

    int n_vec = 0;
    int n_err = 0;

    uart_rx_fifo #(.DEPTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .uart_byte       (uart_byte),
        .uart_byte_ready (uart_byte_ready),
        .cs              (cs),
        .reg_sel         (reg_sel),
        .we              (we),
        .wdata           (wdata),
        .rdata           (rdata),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        uart_byte = b;
        uart_byte_ready = 1'b1;
        tick();
        uart_byte_ready = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [7:0] val);
        cs = 1'b1; we = 1'b0; reg_sel = sel;
        #1;
        val = rdata;
        tick();
        cs = 1'b0;
    endtask

    task automatic push_rd(input logic [7:0] b, output logic [7:0] val);
        uart_byte = b;
        uart_byte_ready = 1'b1;
        rd(2'd0, val);
        uart_byte_ready = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; reg_sel = sel; wdata = d;
        tick();
        cs = 1'b0; we = 1'b0; wdata = 8'h00;
    endtask

    logic [7:0] v;

    initial begin
        reset = 1'b1; uart_byte = 8'h00; uart_byte_ready = 1'b0;
        cs = 1'b0; reg_sel = 2'd0; we = 1'b0; wdata = 8'h00;
        tick(); tick();
        reset = 1'b0;

        // reset state
        rd(2'd1, v); chk("rst_status", v, 8'h10);
        rd(2'd0, v); chk("rst_data", v, 8'h00);
        rd(2'd2, v); chk("rst_ctrl", v, 8'h01);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        reg_sel = 2'd1; #1; chk("cs_low_rdata", rdata, 8'h00);

        // basic path
        push(8'h41);
        chk("basic_irq_up", {7'b0, irq}, 8'h01);
        rd(2'd1, v); chk("basic_status", v, 8'h41);
        rd(2'd0, v); chk("basic_data", v, 8'h41);
        rd(2'd1, v); chk("basic_status_empty", v, 8'h10);
        chk("basic_irq_down", {7'b0, irq}, 8'h00);

        // ordering and wrap
        for (int i = 1; i <= 8; i++) push(8'(i));
        rd(2'd1, v); chk("wrap_full_status", v, 8'h68);
        for (int i = 1; i <= 3; i++) begin
            rd(2'd0, v); chk("wrap_first3", v, 8'(i));
        end
        for (int i = 9; i <= 11; i++) push(8'(i));
        for (int i = 4; i <= 11; i++) begin
            rd(2'd0, v); chk("wrap_seq", v, 8'(i));
        end
        rd(2'd1, v); chk("wrap_empty_status", v, 8'h10);
        rd(2'd3, v); chk("reg3_read", v, 8'h00);

        // overflow
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        push(8'hEE);
        rd(2'd1, v); chk("ovf_status", v, 8'hE8);
        wr(2'd1, 8'h80);
        rd(2'd1, v); chk("ovf_cleared", v, 8'h68);
        for (int i = 0; i < 8; i++) begin
            rd(2'd0, v); chk("ovf_drain", v, 8'h10 + 8'(i));
        end
        rd(2'd1, v); chk("ovf_empty", v, 8'h10);

        // simultaneous push and pop while full
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        push_rd(8'h55, v); chk("sim_old_head", v, 8'h20);
        rd(2'd1, v); chk("sim_status", v, 8'h68);
        for (int i = 1; i < 8; i++) begin
            rd(2'd0, v); chk("sim_drain", v, 8'h20 + 8'(i));
        end
        rd(2'd0, v); chk("sim_last", v, 8'h55);
        rd(2'd0, v); chk("pop_empty_data", v, 8'h00);
        rd(2'd1, v); chk("pop_empty_status", v, 8'h10);

        // control: irq enable and flush
        push(8'h31); push(8'h32); push(8'h33);
        chk("ctl_irq_on", {7'b0, irq}, 8'h01);
        wr(2'd2, 8'h00);
        chk("ctl_irq_off", {7'b0, irq}, 8'h00);
        rd(2'd1, v); chk("ctl_status_masked", v, 8'h03);
        rd(2'd2, v); chk("ctl_en_read0", v, 8'h00);
        wr(2'd2, 8'h03);
        rd(2'd1, v); chk("ctl_flush_status", v, 8'h10);
        rd(2'd2, v); chk("ctl_en_read1", v, 8'h01);
        chk("ctl_flush_irq", {7'b0, irq}, 8'h00);
        push(8'h7F);
        chk("ctl_push_irq", {7'b0, irq}, 8'h01);
        rd(2'd1, v); chk("ctl_push_status", v, 8'h41);

        // flush and push in the same cycle: flush wins, no overflow
        uart_byte = 8'h99; uart_byte_ready = 1'b1;
        wr(2'd2, 8'h03);
        uart_byte_ready = 1'b0;
        rd(2'd1, v); chk("flush_push_status", v, 8'h10);

        // reset mid-operation with a concurrent byte strobe
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
        push(8'hEE);
        for (int i = 0; i < 3; i++) begin
            rd(2'd0, v); chk("pre_rst_drain", v, 8'h60 + 8'(i));
        end
        rd(2'd1, v); chk("pre_rst_status", v, 8'hC5);
        reset = 1'b1; uart_byte = 8'hA5; uart_byte_ready = 1'b1;
        tick();
        reset = 1'b0; uart_byte_ready = 1'b0;
        rd(2'd1, v); chk("mid_rst_status", v, 8'h10);
        rd(2'd2, v); chk("mid_rst_ctrl", v, 8'h01);
        chk("mid_rst_irq", {7'b0, irq}, 8'h00);
        rd(2'd0, v); chk("mid_rst_data", v, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
